// File: rtl/heaa_pipe_adder_if.sv
// Streaming operand/result bundle for heaa_pipe_adder.
// The master drives the operands and out_ready. The slave is the adder.
interface heaa_pipe_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_exact;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;

    modport master (
        output in_valid, in_a, in_b, in_exact, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_a, in_b, in_exact, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/heaa_pipe_adder.sv
// Two-stage streaming HEAA adder: approximate low INACC bits with an exact block-CLA upper part.
// Define HEAA_ERR_STATS_EN to compile in the error counter (stats_clr / err_cnt).
module heaa_pipe_adder #(
    parameter int WIDTH   = 32,
    parameter int INACC   = 9,
    parameter int CLA_BLK = 4
) (
    input  logic          clk,
    input  logic          rst,
    heaa_pipe_adder_if.slave bus
`ifdef HEAA_ERR_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [15:0]   err_cnt
`endif
);
    localparam int K    = INACC;
    localparam int UW   = WIDTH - INACC;
    localparam int NBLK = (UW + CLA_BLK - 1) / CLA_BLK;

    // Handshake
    logic en1, en2;
    logic s1_valid_q;
    logic out_valid_q;

    assign en2          = !out_valid_q || bus.out_ready;
    assign en1          = !s1_valid_q || en2;
    assign bus.in_ready = en1;

    // Stage 1: low part, carry into bit K, and the upper operand slices
    logic [K-1:0]  low_approx;
    logic          ck_approx;
    logic [K:0]    low_exact;
    logic [K-1:0]  s1_low_d, s1_low_q;
    logic          s1_c_d, s1_c_q;
    logic [UW-1:0] s1_a_q, s1_b_q;

    assign low_approx = {bus.in_a[K-1] ^ bus.in_b[K-1], bus.in_a[K-2:0] | bus.in_b[K-2:0]};
    assign ck_approx  = bus.in_a[K-1] & bus.in_b[K-1];
    assign low_exact  = {1'b0, bus.in_a[K-1:0]} + {1'b0, bus.in_b[K-1:0]};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        s1_low_d = low_approx;
        s1_c_d   = ck_approx;
        if (bus.in_exact) begin
            s1_low_d = low_exact[K-1:0];
            s1_c_d   = low_exact[K];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, so out_sum reads 0 straight after reset.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_low_q   <= '0;
            s1_c_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (en1) begin
            // NOTE: sequential state always uses non-blocking assignments.
            s1_valid_q <= bus.in_valid;
            s1_low_q   <= s1_low_d;
            s1_c_q     <= s1_c_d;
            s1_a_q     <= bus.in_a[WIDTH-1:K];
            s1_b_q     <= bus.in_b[WIDTH-1:K];
        end
    end

    // Stage 2: block carry-lookahead over the upper slice
    logic [UW-1:0] cla_g, cla_p, cla_c;
    logic [NBLK:0] blk_c;
    logic          grp_g, grp_p;
    logic [UW-1:0] hi_sum;

    always_comb begin
        cla_g    = s1_a_q & s1_b_q;
        cla_p    = s1_a_q ^ s1_b_q;
        cla_c    = '0;
        blk_c    = '0;
        blk_c[0] = s1_c_q;
        grp_g    = 1'b0;
        grp_p    = 1'b1;
        for (int j = 0; j < NBLK; j++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int k = 0; k < CLA_BLK; k++) begin
                if (j * CLA_BLK + k < UW) begin
                    cla_c[j*CLA_BLK+k] = grp_g | (grp_p & blk_c[j]);
                    grp_g = cla_g[j*CLA_BLK+k] | (cla_p[j*CLA_BLK+k] & grp_g);
                    grp_p = grp_p & cla_p[j*CLA_BLK+k];
                end
            end
            blk_c[j+1] = grp_g | (grp_p & blk_c[j]);
        end
    end

    assign hi_sum = cla_p ^ cla_c;

    logic [WIDTH:0] out_sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else if (en2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sum_q <= {blk_c[NBLK], hi_sum, s1_low_q};
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;

`ifdef HEAA_ERR_STATS_EN
    // An approximate beat is wrong exactly when its low bits or carry-in to bit K differ.
    logic        err1_d;
    logic        s1_err_q, out_err_q;
    logic [15:0] err_cnt_d, err_cnt_q;

    assign err1_d = !bus.in_exact && ({ck_approx, low_approx} != low_exact);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (stats_clr) begin
            err_cnt_d = '0;
        end else if (out_valid_q && bus.out_ready && out_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_err_q  <= 1'b0;
            out_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (en1) s1_err_q  <= err1_d;
            if (en2) out_err_q <= s1_err_q;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_heaa_pipe_adder.sv
// Self-checking bench for heaa_pipe_adder (WIDTH=32, INACC=9) with an arithmetic reference model.
// Error-counter checks are active when HEAA_ERR_STATS_EN is defined.
module tb_heaa_pipe_adder;
    localparam int W = 32;
    localparam int K = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    heaa_pipe_adder_if #(.WIDTH(W)) bus ();

`ifdef HEAA_ERR_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] err_cnt;
`endif

    heaa_pipe_adder #(.WIDTH(W), .INACC(K), .CLA_BLK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef HEAA_ERR_STATS_EN
        ,
        .stats_clr (stats_clr),
        .err_cnt   (err_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: approximate result built from the bit rules with plain integer arithmetic.
    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic ex);
        longint unsigned la, lb, orp, mid, ck, up;
        la = 64'(a);
        lb = 64'(b);
        if (ex) return (W+1)'(la + lb);
        orp = (la | lb) & ((64'd1 << (K-1)) - 64'd1);
        mid = ((la ^ lb) >> (K-1)) & 64'd1;
        ck  = (la >> (K-1)) & (lb >> (K-1)) & 64'd1;
        up  = (la >> K) + (lb >> K) + ck;
        return (W+1)'((up << K) | (mid << (K-1)) | orp);
    endfunction

    function automatic bit model_err(input logic [W-1:0] a, input logic [W-1:0] b, input logic ex);
        return !ex && (model_sum(a, b, 1'b0) != model_sum(a, b, 1'b1));
    endfunction

    typedef struct {
        logic [W:0] sum;
        bit         err;
    } exp_t;

    exp_t        sb[$];
    int          tx_count = 0;
    bit          prev_stall = 0;
    logic [W:0]  prev_sum;
    logic [15:0] m_cnt = '0;

    // Compare process: scoreboard, output-hold rule and error counter.
    always @(negedge clk) begin
        exp_t e;
        bit   err_now;
        if (rst) begin
            sb.delete();
            prev_stall = 0;
            m_cnt      = '0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_sum", 64'(bus.out_sum), 64'(prev_sum));
            end
            err_now = 0;
            if (bus.out_valid && bus.out_ready) begin
                tx_count++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("sb_sum", 64'(bus.out_sum), 64'(e.sum));
                    err_now = e.err;
                end
            end
`ifdef HEAA_ERR_STATS_EN
            check("err_cnt", 64'(err_cnt), 64'(m_cnt));
            if (stats_clr) m_cnt = '0;
            else if (err_now && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            if (bus.in_valid && bus.in_ready) begin
                e.sum = model_sum(bus.in_a, bus.in_b, bus.in_exact);
                e.err = model_err(bus.in_a, bus.in_b, bus.in_exact);
                sb.push_back(e);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.out_sum;
        end
    end

    // Single beat with out_ready=1; result must be visible two cycles after presentation.
    task automatic do_beat(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ex, input logic [W:0] exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_exact = ex;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({name, "_s1_only"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check(name, 64'(bus.out_sum), 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic push_beats(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ex);
        int sent  = 0;
        int guard = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_exact = ex;
        bus.in_valid = 1'b1;
        while (sent < n && guard < n + 100) begin
            @(negedge clk);
            if (bus.in_ready) sent++;
            guard++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("push_sent", 64'(sent), 64'(n));
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int tx_before;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_exact  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_sum", 64'(bus.out_sum), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef HEAA_ERR_STATS_EN
        check("reset_err_cnt", 64'(err_cnt), 64'd0);
`endif

        // Pin the reference model with hand-computed values
        check("model_or_low", 64'(model_sum(32'h0000_00FF, 32'h0000_0001, 1'b0)), 64'h0_0000_00FF);
        check("model_ck_path", 64'(model_sum(32'h0000_0100, 32'h0000_0100, 1'b0)), 64'h0_0000_0200);
        check("model_all_ones", 64'(model_sum(32'hFFFF_FFFF, 32'h0000_0001, 1'b0)), 64'h0_FFFF_FFFF);
        check("model_exact", 64'(model_sum(32'hFFFF_FFFF, 32'h0000_0001, 1'b1)), 64'h1_0000_0000);
        check("model_err_flag", 64'(model_err(32'h0000_00FF, 32'h0000_0001, 1'b0)), 64'd1);

        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        do_beat("approx_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_00FF);
`ifdef HEAA_ERR_STATS_EN
        check("err_after_ff_1", 64'(err_cnt), 64'd1);
`endif
        do_beat("approx_ck", 32'h0000_0100, 32'h0000_0100, 1'b0, 33'h0_0000_0200);
`ifdef HEAA_ERR_STATS_EN
        check("err_after_ck", 64'(err_cnt), 64'd1);
`endif
        do_beat("approx_ones", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_FFFF_FFFF);
        do_beat("exact_ones", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33'h1_0000_0000);
`ifdef HEAA_ERR_STATS_EN
        check("err_after_ones", 64'(err_cnt), 64'd2);
`endif
        do_beat("exact_mix", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 33'h0_ACF1_3568);
        do_beat("approx_msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);

        // 8-beat stream, out_ready low in cycles 3..6
        tx_before = tx_count;
        sent = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            @(posedge clk); #1;
            bus.out_ready = !(c >= 3 && c <= 6);
            bus.in_valid  = 1'b1;
            bus.in_a      = 32'h0101_0000 * (sent + 1) + 32'(sent * 37);
            bus.in_b      = 32'h00FF_01FF ^ 32'(sent << 5);
            bus.in_exact  = sent[0];
            #1;
            if (c >= 3 && c <= 6) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            if (c == 7) check("resume_in_ready", 64'(bus.in_ready), 64'd1);
            if (bus.in_ready) sent++;
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_sent", 64'(sent), 64'd8);
        drain();
        check("stream_count", 64'(tx_count - tx_before), 64'd8);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h0000_1111;
        bus.in_b      = 32'h0000_2222;
        bus.in_exact  = 1'b1;
        @(posedge clk); #1;
        bus.in_a      = 32'h0000_3333;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_sum", 64'(bus.out_sum), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_stale", 64'(bus.out_valid), 64'd0);
        end

`ifdef HEAA_ERR_STATS_EN
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk); #1;
        push_beats(65534, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        drain();
        check("err_fffe", 64'(err_cnt), 64'hFFFE);
        push_beats(3, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        drain();
        check("err_saturate", 64'(err_cnt), 64'hFFFF);

        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_a     = 32'h0000_00FF;
            bus.in_b     = 32'h0000_0001;
            bus.in_exact = 1'b0;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            stats_clr = (r != 1);
            @(posedge clk); #1;
            stats_clr = 1'b0;
            check("clr_vs_incr", 64'(err_cnt), (r == 1) ? 64'd1 : 64'd0);
        end
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
